zion_basic_circuit_lib_skid_buf: RTL

ZION_BASIC_CIRCUIT_LIB_SKID_BUF -- requirements
Module: zion_basic_circuit_lib_skid_buf

---
 rtl/zion_basic_circuit_lib_pkg.sv | 15 +
 rtl/zion_basic_circuit_lib_en_rc_dff.sv | 35 +++
 rtl/zion_basic_circuit_lib_skid_buf.sv | 114 +++++++++++
 3 files changed

// File: rtl/zion_basic_circuit_lib_pkg.sv
// Shared types for the basic circuit library: skid buffer FSM states and reset configuration codes.
package zion_basic_circuit_lib_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

  // Reset flavours understood by ZionBasicCircuitLib_EnRcDff.
  localparam int RST_SYNC_HIGH  = 0;
  localparam int RST_ASYNC_HIGH = 1;
  localparam int RST_ASYNC_LOW  = 2;

endpackage

// File: rtl/zion_basic_circuit_lib_en_rc_dff.sv
// Enabled data register with selectable reset flavour; holds its value whenever en is low.
module ZionBasicCircuitLib_EnRcDff
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               RST_CFG = RST_ASYNC_HIGH,
  parameter logic [WIDTH-1:0] INI     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (RST_CFG == RST_ASYNC_HIGH) begin : g_async_high
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= INI;
        else if (en) q <= d;
      end
    end else if (RST_CFG == RST_ASYNC_LOW) begin : g_async_low
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= INI;
        else if (en) q <= d;
      end
    end else begin : g_sync_high
      always_ff @(posedge clk) begin
        if (rst)     q <= INI;
        else if (en) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/zion_basic_circuit_lib_skid_buf.sv
// Two-entry skid buffer: fully registered valid/ready/data so neither handshake direction
// has a combinational path through the block; 1-cycle latency, full throughput.
module zion_basic_circuit_lib_skid_buf
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat
);

  generate
    if (WIDTH < 1) begin : g_param_err
`ifdef CHECK_ERR_EXIT
      $fatal(1, "zion_basic_circuit_lib_skid_buf: WIDTH must be >= 1");
`else
      $error("zion_basic_circuit_lib_skid_buf: WIDTH must be >= 1");
`endif
    end
  endgenerate

  skid_state_e      state_q, state_d;
  logic             vld_q, rdy_q;
  logic             up_xfer, dn_xfer;
  logic             main_en, skid_en, main_from_skid;
  logic [WIDTH-1:0] main_d, skid_q;

  assign up_xfer = iVld && rdy_q;
  assign dn_xfer = vld_q && iRdy;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (up_xfer && dn_xfer) begin
          main_en = 1'b1;
        end else if (dn_xfer) begin
          state_d = EMPTY;
        end else if (up_xfer) begin
          skid_en = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        // oRdy is low here, so only the downstream side can make progress.
        if (dn_xfer) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign main_d = main_from_skid ? skid_q : iDat;

  // Handshake outputs are registered from the next state rather than decoded from state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      vld_q   <= (state_d != EMPTY);
      rdy_q   <= (state_d != FULL);
    end
  end

  assign oVld = vld_q;
  assign oRdy = rdy_q;

  ZionBasicCircuitLib_EnRcDff #(
    .WIDTH   (WIDTH),
    .RST_CFG (RST_ASYNC_HIGH),
    .INI     (INI_DATA)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (oDat)
  );

  ZionBasicCircuitLib_EnRcDff #(
    .WIDTH   (WIDTH),
    .RST_CFG (RST_ASYNC_HIGH),
    .INI     (INI_DATA)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (iDat),
    .q   (skid_q)
  );

endmodule
